// File: rtl/four_bank_mem_ctl.sv
// four_bank_mem_ctl: four word-interleaved memory banks with per-bank busy timers,
// a fixed 2-cycle read pipeline and registered illegal-request flag.
module four_bank_mem_ctl #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int BANK_DEPTH = 8192,
    parameter int RD_LAT     = 2,
    parameter int BUSY_CYC   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              wr,
    input  logic              rd,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              stall,
    output logic [3:0]        busy,
    output logic              err
);
    localparam int ROW_W = $clog2(BANK_DEPTH);
    localparam int CW    = $clog2(BUSY_CYC);

    logic [CW-1:0]      cnt [4];
    logic [DATA_W-1:0]  mem [4*BANK_DEPTH];
    logic [1:0]         bank;
    logic [ROW_W-1:0]   row;
    logic               legal, illegal, acc, v1;
    logic [DATA_W-1:0]  d1;

    assign bank    = addr[2:1];
    assign row     = addr[ROW_W+2:3];
    assign legal   = (rd ^ wr) & ~addr[0];
    assign illegal = (rd & wr) | ((rd | wr) & addr[0]);
    assign acc     = legal & ~busy[bank];
    // illegal requests are rejected via err, never via stall
    assign stall   = legal & busy[bank];

    always_comb begin
        for (int i = 0; i < 4; i++) busy[i] = cnt[i] != '0;
    end

    // array and stage-1 data carry no reset so they map onto plain RAM
    always_ff @(posedge clk) begin
        if (acc && wr) mem[{bank, row}] <= data_in;
        if (acc && rd) d1 <= mem[{bank, row}];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
            v1         <= 1'b0;
            data_valid <= 1'b0;
            data_out   <= '0;
            err        <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++)
                cnt[i] <= (acc && bank == 2'(i)) ? CW'(BUSY_CYC - 1) :
                          (cnt[i] != '0) ? cnt[i] - 1'b1 : '0;
            v1         <= acc & rd;
            data_valid <= v1;
            data_out   <= v1 ? d1 : '0;
            err        <= illegal;
        end
    end
endmodule

// File: tb/tb_four_bank_mem_ctl.sv
// tb_four_bank_mem_ctl: directed scenarios plus random traffic checked against
// a cycle-count reference model of bank availability and read return times.
module tb_four_bank_mem_ctl;
    logic        clk = 1'b0, rst, rd, wr, data_valid, stall, err;
    logic [15:0] addr, data_in, data_out;
    logic [3:0]  busy;

    four_bank_mem_ctl dut (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .wr(wr), .rd(rd),
        .data_out(data_out), .data_valid(data_valid), .stall(stall), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [15:0] d; } rd_t;

    int          total = 0, bad = 0, cyc = 0;
    logic [15:0] mem_m [int];
    int          free_at [4];
    rd_t         q [$];
    logic        err_m = 1'b0;
    logic        acc;
    logic [15:0] pool [12];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // one clock cycle: drive, check mid-cycle against the model, advance model
    task automatic step(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                        output logic ok);
        logic [3:0] bz;
        logic [1:0] b;
        logic       lg, ill;
        rd_t        e;
        rd = r; wr = w; addr = a; data_in = d;
        #3;
        b = a[2:1];
        for (int i = 0; i < 4; i++) bz[i] = cyc < free_at[i];
        lg  = (r ^ w) & ~a[0];
        ill = (r & w) | ((r | w) & a[0]);
        ok  = lg & ~bz[b];
        chk("busy", {28'd0, busy}, {28'd0, bz});
        chk("stall", {31'd0, stall}, {31'd0, lg & bz[b]});
        chk("err", {31'd0, err}, {31'd0, err_m});
        if (q.size() != 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("valid", {31'd0, data_valid}, 32'd1);
            chk("dout", {16'd0, data_out}, {16'd0, e.d});
        end else begin
            chk("valid", {31'd0, data_valid}, 32'd0);
            chk("dout", {16'd0, data_out}, 32'd0);
        end
        if (ok && w) mem_m[int'(a)] = d;
        if (ok && r) q.push_back('{due: cyc + 2, d: mem_m[int'(a)]});
        if (ok) free_at[b] = cyc + 4;
        err_m = ill;
        @(posedge clk); #1; cyc++;
    endtask

    task automatic idle(input int n);
        logic ok;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 16'h0, ok);
    endtask

    // retry until accepted, bounded
    task automatic send(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                        output int stalls);
        logic ok;
        ok = 1'b0;
        stalls = 0;
        for (int k = 0; k < 8 && !ok; k++) begin
            step(r, w, a, d, ok);
            if (!ok) stalls++;
        end
        chk("send_accepted", {31'd0, ok}, 32'd1);
    endtask

    task automatic pulse_reset();
        rd = 1'b0; wr = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", {28'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_dout", {16'd0, data_out}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(posedge clk); #1; cyc++;
        rst = 1'b0;
        q.delete();
        err_m = 1'b0;
        for (int i = 0; i < 4; i++) free_at[i] = 0;
    endtask

    initial begin
        int n;
        logic r, w;
        logic [15:0] a;
        for (int i = 0; i < 4; i++) free_at[i] = 0;
        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(1);

        // read-after-write to the same word waits out the bank
        send(1'b0, 1'b1, 16'h0010, 16'hBEEF, n);
        send(1'b1, 1'b0, 16'h0010, 16'h0, n);
        chk("t1_stalls", n, 3);
        idle(3);

        // line fill pipelines across the four banks
        for (int i = 0; i < 4; i++) send(1'b0, 1'b1, 16'h1230 + 16'(2 * i), 16'hA000 + 16'(i), n);
        idle(4);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 16'h1230 + 16'(2 * i), 16'h0, acc);
            chk("t2_acc", {31'd0, acc}, 32'd1);
        end
        idle(3);

        // writeback then refill read of the first word
        for (int i = 0; i < 4; i++) send(1'b0, 1'b1, 16'h0F08 + 16'(2 * i), 16'($urandom), n);
        send(1'b1, 1'b0, 16'h0F08, 16'h0, n);
        idle(3);

        // illegal requests
        step(1'b1, 1'b1, 16'h0004, 16'h1111, acc);
        step(1'b1, 1'b0, 16'h0003, 16'h0, acc);
        idle(2);

        // reset with a read in flight, array survives
        send(1'b0, 1'b1, 16'h2000, 16'h5A5A, n);
        idle(4);
        send(1'b1, 1'b0, 16'h2000, 16'h0, n);
        pulse_reset();
        idle(3);
        send(1'b1, 1'b0, 16'h2000, 16'h0, n);
        idle(3);

        // random traffic over a pre-written address pool
        for (int i = 0; i < 12; i++) begin
            pool[i] = {13'($urandom), 2'(i), 1'b0};
            send(1'b0, 1'b1, pool[i], 16'($urandom), n);
        end
        for (int i = 0; i < 400; i++) begin
            r = 1'($urandom);
            w = 1'($urandom);
            a = pool[$urandom_range(0, 11)];
            if ($urandom_range(0, 15) == 0) a[0] = 1'b1;
            step(r, w, a, 16'($urandom), acc);
            if (i == 200) pulse_reset();
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
